// File: rtl/noc_axi4_bridge_pkg.sv
// Shared types and helpers for the noc_axi4_bridge read/write arbitration.
// Bus-width macros default here when the surrounding build does not supply them.
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 64
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 6
`endif
`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 64
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 3
`endif

package noc_axi4_bridge_pkg;

  localparam int RR_MAX_N     = 8;
  localparam int RR_MAX_IDX_W = 3;

  typedef enum logic {ARB, ISSUE} rd_arb_state_t;

  // Returns {found, idx}: first set bit of req at or after ptr, wrapping modulo n.
  function automatic logic [RR_MAX_IDX_W:0] rr_pick(
    input logic [RR_MAX_N-1:0]     req,
    input logic [RR_MAX_IDX_W-1:0] ptr,
    input int unsigned             n
  );
    logic [RR_MAX_IDX_W:0]   res;
    logic [RR_MAX_IDX_W-1:0] cand_idx;
    int unsigned             cand;
    res = '0;
    for (int unsigned k = 0; k < RR_MAX_N; k++) begin
      cand     = (32'(ptr) + k) % n;
      cand_idx = cand[RR_MAX_IDX_W-1:0];
      if ((k < n) && !res[RR_MAX_IDX_W] && req[cand_idx])
        res = {1'b1, cand_idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/noc_axi4_rr_arbiter.sv
// Combinational round-robin picker over N requesters, starting at ptr.
module noc_axi4_rr_arbiter
  import noc_axi4_bridge_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_found
);

  logic [RR_MAX_N-1:0]     req_ext;
  logic [RR_MAX_IDX_W-1:0] ptr_ext;
  logic [RR_MAX_IDX_W:0]   pick;

  always_comb begin
    req_ext          = '0;
    req_ext[N-1:0]   = req;
    ptr_ext          = '0;
    ptr_ext[IDX_W-1:0] = ptr;
    pick             = rr_pick(req_ext, ptr_ext, N);
    gnt_found        = pick[RR_MAX_IDX_W];
    gnt_idx          = pick[IDX_W-1:0];
  end

endmodule

// File: rtl/noc_axi4_bridge_rd_arb.sv
// Shares one bridge read channel among NUM_REQ requesters; the requester index
// rides in the AXI ID upper bits and steers responses back.
module noc_axi4_bridge_rd_arb
  import noc_axi4_bridge_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MAX_OUT = 4,
  localparam int IDX_W  = $clog2(NUM_REQ),
  localparam int AW     = `AXI4_ADDR_WIDTH,
  localparam int SW     = `MSG_DATA_SIZE_WIDTH,
  localparam int IW     = `AXI4_ID_WIDTH,
  localparam int DW     = `AXI4_DATA_WIDTH,
  localparam int TW     = IW - IDX_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      up_req_val,
  input  logic [NUM_REQ*AW-1:0]   up_req_addr,
  input  logic [NUM_REQ*SW-1:0]   up_req_size_log,
  input  logic [NUM_REQ*TW-1:0]   up_req_tag,
  output logic [NUM_REQ-1:0]      up_req_rdy,
  output logic [NUM_REQ-1:0]      up_resp_val,
  output logic [TW-1:0]           up_resp_tag,
  output logic [DW-1:0]           up_resp_data,
  input  logic [NUM_REQ-1:0]      up_resp_rdy,
  output logic                    req_val,
  output logic [AW-1:0]           req_addr,
  output logic [SW-1:0]           req_size_log,
  output logic [IW-1:0]           req_id,
  input  logic                    req_rdy,
  input  logic                    resp_val,
  input  logic [IW-1:0]           resp_id,
  input  logic [DW-1:0]           resp_data,
  output logic                    resp_rdy,
  output logic                    err_orphan
);

  localparam int              CNT_W   = 4;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  rd_arb_state_t      state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   out_cnt [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_found;
  logic               grant;
  logic [IDX_W-1:0]   sel;
  logic               resp_fire;
  logic [NUM_REQ-1:0] cnt_inc;
  logic [NUM_REQ-1:0] cnt_dec;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = up_req_val[i] & (out_cnt[i] != MAX_CNT);
  end

  noc_axi4_rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req       (eligible),
    .ptr       (rr_ptr),
    .gnt_idx   (gnt_idx),
    .gnt_found (gnt_found)
  );

  assign grant   = (state == ARB) & gnt_found;
  assign req_val = (state == ISSUE);

  always_comb begin
    up_req_rdy = '0;
    if (grant)
      up_req_rdy[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB;
      rr_ptr       <= '0;
      req_addr     <= '0;
      req_size_log <= '0;
      req_id       <= '0;
    end else begin
      case (state)
        ARB: begin
          if (grant) begin
            req_addr     <= up_req_addr[gnt_idx*AW +: AW];
            req_size_log <= up_req_size_log[gnt_idx*SW +: SW];
            req_id       <= {gnt_idx, up_req_tag[gnt_idx*TW +: TW]};
            rr_ptr       <= gnt_idx + 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          if (req_rdy)
            state <= ARB;
        end
      endcase
    end
  end

  // Response demux: unbuffered, steered by the index field of the ID.
  assign sel          = resp_id[IW-1 -: IDX_W];
  assign up_resp_tag  = resp_id[TW-1:0];
  assign up_resp_data = resp_data;
  assign resp_rdy     = up_resp_rdy[sel];
  assign resp_fire    = resp_val & resp_rdy;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      up_resp_val[i] = resp_val & (sel == IDX_W'(i));
      cnt_inc[i]     = grant & (gnt_idx == IDX_W'(i));
      cnt_dec[i]     = resp_fire & (sel == IDX_W'(i)) & (out_cnt[i] != '0);
    end
  end

  // Counting at grant keeps requests still queued inside the bridge under the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++)
        out_cnt[i] <= '0;
      err_orphan <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (cnt_inc[i] && !cnt_dec[i])
          out_cnt[i] <= out_cnt[i] + 1'b1;
        else if (cnt_dec[i] && !cnt_inc[i])
          out_cnt[i] <= out_cnt[i] - 1'b1;
      end
      if (resp_fire && (out_cnt[sel] == '0))
        err_orphan <= 1'b1;
    end
  end

endmodule
